dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port byte-addressed data memory (128 bytes, word access, write on posedge, combinational read).
- Port 0 is the CPU load/store path. Port 1 is the testbench/DMA loader.
- Grants one word access at a time, round-robin, with a req/ack handshake per requester.
- Drives the memory's address, write data, read strobe and write strobe; checks alignment and range before touching memory.

---
 rtl/dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and sequencer in front of a single-port, byte-addressed
// data memory (word access, write on posedge, combinational read). Port 0 is the
// CPU load/store path, port 1 the DMA/loader path. One word access is granted
// at a time through a three-state sequence IDLE -> ACCESS -> RESP. Alignment and
// range are checked before the memory is touched; illegal accesses complete
// with an error flag and never raise a memory strobe.
//
// Configuration macro:
//   DMEM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins simultaneous requests.
//                           undefined : round-robin between the two ports.
//
// Ports:
//   clk_i                 clock, rising edge
//   rst_i                 asynchronous reset, active-low
//   mN_req_i              port N request, held with we/addr/wdata until ack
//   mN_we_i               port N direction (1 = write, 0 = read)
//   mN_addr_i             port N byte address
//   mN_wdata_i            port N write data
//   mN_ack_o              port N one-cycle completion pulse
//   mN_err_o              port N error, valid with ack
//   mN_rdata_o            port N read data, held until the next port-N read
//   mem_addr_o            memory byte address (non-zero only during a legal access)
//   mem_data_o            memory write data
//   mem_read_o            memory read strobe
//   mem_write_o           memory write strobe
//   mem_data_i            memory read data (combinational from mem_addr_o)
//   busy_o                high in any state other than IDLE
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Highest word-aligned address; compared over the full address width so any
  // upper bit set is out of range.
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 4);

  // Legal access: word aligned and inside the memory.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    logic ok;
    ok = (addr[1:0] == 2'b00) && (addr <= LAST_WORD_ADDR);
    return ok;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic                port_q,      port_d;      // granted port id
  logic                we_q,        we_d;        // latched direction
  logic                legal_q,     legal_d;     // latched legality result
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q,  mem_data_d;
  logic                mem_read_q,  mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                ack0_q,      ack0_d;
  logic                ack1_q,      ack1_d;
  logic                err0_q,      err0_d;
  logic                err1_q,      err1_d;
  logic [DATA_W-1:0]   rdata0_q,    rdata0_d;
  logic [DATA_W-1:0]   rdata1_q,    rdata1_d;
  logic                busy_q,      busy_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                last_grant_q, last_grant_d;
`endif

  // Arbitration result and the selected requester's command.
  logic                gnt_valid_s;
  logic                gnt_port_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                sel_legal_s;

  // Pick the winning port from the current requests.
  always_comb begin
    gnt_valid_s = m0_req_i | m1_req_i;
    gnt_port_s  = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (m0_req_i) begin
      gnt_port_s = 1'b0;
    end else begin
      gnt_port_s = 1'b1;
    end
`else
    // On a tie the port that did not win last time goes next.
    if (m0_req_i && m1_req_i) begin
      gnt_port_s = ~last_grant_q;
    end else if (m0_req_i) begin
      gnt_port_s = 1'b0;
    end else begin
      gnt_port_s = 1'b1;
    end
`endif
  end

  // Route the winning port's command and pre-compute its legality.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (gnt_port_s) begin
      sel_we_s    = m1_we_i;
      sel_addr_s  = m1_addr_i;
      sel_wdata_s = m1_wdata_i;
    end else begin
      sel_we_s    = m0_we_i;
      sel_addr_s  = m0_addr_i;
      sel_wdata_s = m0_wdata_i;
    end
    sel_legal_s = addr_legal(sel_addr_s);
  end

  // Next-state and next-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    legal_d      = legal_q;
    // Memory bus and acks are zero unless the transition below sets them.
    mem_addr_d   = '0;
    mem_data_d   = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    busy_d       = busy_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (gnt_valid_s) begin
          state_d = S_ACCESS;
          port_d  = gnt_port_s;
          we_d    = sel_we_s;
          legal_d = sel_legal_s;
          busy_d  = 1'b1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_grant_d = gnt_port_s;
`endif
          // The bus is loaded here so that it is valid for the whole ACCESS
          // cycle; an illegal command leaves it parked at zero.
          if (sel_legal_s) begin
            mem_addr_d  = sel_addr_s;
            mem_data_d  = sel_wdata_s;
            mem_write_d = sel_we_s;
            mem_read_d  = ~sel_we_s;
          end else begin
            mem_addr_d  = '0;
            mem_data_d  = '0;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      S_ACCESS: begin
        state_d = S_RESP;
        busy_d  = 1'b1;
        // Read data is valid combinationally from the memory during ACCESS.
        if (legal_q && !we_q) begin
          if (port_q) begin
            rdata1_d = mem_data_i;
          end else begin
            rdata0_d = mem_data_i;
          end
        end else begin
          rdata0_d = rdata0_q;
          rdata1_d = rdata1_q;
        end
        if (port_q) begin
          ack1_d = 1'b1;
          err1_d = ~legal_q;
        end else begin
          ack0_d = 1'b1;
          err0_d = ~legal_q;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      legal_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      busy_q       <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      legal_q      <= legal_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      busy_q       <= busy_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign m0_ack_o    = ack0_q;
  assign m0_err_o    = err0_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_ack_o    = ack1_q;
  assign m1_err_o    = err1_q;
  assign m1_rdata_o  = rdata1_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a 128-byte behavioural memory (write on
// posedge, combinational read). Inputs are driven and outputs sampled 1 ns
// after the rising edge. Expected order for simultaneous requests follows the
// DMEM_ARB_FIXED_PRIO_EN build setting.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_i;
  logic        m0_req_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i;
  logic        m0_ack_o, m0_err_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_wdata_i;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m1_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        mem_read_o, mem_write_o;
  logic [31:0] mem_data_i;
  logic        busy_o;

  logic [31:0] mem [0:31];
  logic        tb_clear;

  int n_cmp  = 0;
  int n_fail = 0;

  int cyc_cnt = 0, busy_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  int a0_cnt = 0, a1_cnt = 0, dual_cnt = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(128)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .m0_req_i   (m0_req_i),
    .m0_we_i    (m0_we_i),
    .m0_addr_i  (m0_addr_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_ack_o   (m0_ack_o),
    .m0_err_o   (m0_err_o),
    .m0_rdata_o (m0_rdata_o),
    .m1_req_i   (m1_req_i),
    .m1_we_i    (m1_we_i),
    .m1_addr_i  (m1_addr_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_ack_o   (m1_ack_o),
    .m1_err_o   (m1_err_o),
    .m1_rdata_o (m1_rdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_read_o (mem_read_o),
    .mem_write_o(mem_write_o),
    .mem_data_i (mem_data_i),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: word index taken from byte address bits [6:2].
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (mem_write_o) begin
      mem[mem_addr_o[6:2]] <= mem_data_o;
    end
  end
  assign mem_data_i = mem[mem_addr_o[6:2]];

  // Activity counters sampled mid-cycle.
  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (busy_o)               busy_cnt <= busy_cnt + 1;
    if (mem_read_o)           rd_cnt   <= rd_cnt + 1;
    if (mem_write_o)          wr_cnt   <= wr_cnt + 1;
    if (m0_ack_o)             a0_cnt   <= a0_cnt + 1;
    if (m1_ack_o)             a1_cnt   <= a1_cnt + 1;
    if (m0_ack_o && m1_ack_o) dual_cnt <= dual_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access on port p starting in IDLE; returns after the edge
  // that ends the ack cycle with req dropped. lat = edges from req to ack.
  task automatic do_access(input logic p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    rdata = 32'h0;
    err = 1'b0;
    if (p) begin
      m1_we_i = we; m1_addr_i = addr; m1_wdata_i = wdata; m1_req_i = 1'b1;
    end else begin
      m0_we_i = we; m0_addr_i = addr; m0_wdata_i = wdata; m0_req_i = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      lat++;
      if (p ? m1_ack_o : m0_ack_o) begin
        got   = 1'b1;
        rdata = p ? m1_rdata_o : m0_rdata_o;
        err   = p ? m1_err_o : m0_err_o;
        break;
      end
    end
    if (!got) lat = 99;
    tick();
    if (p) m1_req_i = 1'b0;
    else   m0_req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          s_rd, s_wr, s_cyc, s_busy, s_a0;
    logic [1:0]  order [0:3];
    logic [1:0]  exp_order [0:3];
    int          n0, n1, no;
    logic        drop0, drop1;

    rst_i = 1'b0; tb_clear = 1'b1;
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = 32'h0; m0_wdata_i = 32'h0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = 32'h0; m1_wdata_i = 32'h0;

    // ---- reset values ----
    repeat (3) tick();
    chk("rst_busy",   {31'h0, busy_o},      32'h0);
    chk("rst_ack0",   {31'h0, m0_ack_o},    32'h0);
    chk("rst_ack1",   {31'h0, m1_ack_o},    32'h0);
    chk("rst_err",    {30'h0, m0_err_o, m1_err_o}, 32'h0);
    chk("rst_rdata0", m0_rdata_o,           32'h0);
    chk("rst_rdata1", m1_rdata_o,           32'h0);
    chk("rst_maddr",  mem_addr_o,           32'h0);
    chk("rst_mdata",  mem_data_o,           32'h0);
    chk("rst_strb",   {30'h0, mem_read_o, mem_write_o}, 32'h0);
    tb_clear = 1'b0;
    rst_i = 1'b1;
    tick();

    // ---- port 0 write 0x08, cycle by cycle ----
    m0_we_i = 1'b1; m0_addr_i = 32'h08; m0_wdata_i = 32'hDEADBEEF; m0_req_i = 1'b1;
    tick();
    chk("wr_acc_we",   {31'h0, mem_write_o}, 32'h1);
    chk("wr_acc_rd",   {31'h0, mem_read_o},  32'h0);
    chk("wr_acc_addr", mem_addr_o,           32'h08);
    chk("wr_acc_data", mem_data_o,           32'hDEADBEEF);
    chk("wr_acc_busy", {31'h0, busy_o},      32'h1);
    chk("wr_acc_ack",  {31'h0, m0_ack_o},    32'h0);
    tick();
    chk("wr_resp_ack", {31'h0, m0_ack_o},    32'h1);
    chk("wr_resp_err", {31'h0, m0_err_o},    32'h0);
    chk("wr_resp_we",  {31'h0, mem_write_o}, 32'h0);
    chk("wr_mem",      mem[2],               32'hDEADBEEF);
    tick();
    m0_req_i = 1'b0;
    chk("wr_idle_ack",  {31'h0, m0_ack_o},   32'h0);
    chk("wr_idle_busy", {31'h0, busy_o},     32'h0);

    // ---- port 0 read back 0x08 ----
    do_access(1'b0, 1'b0, 32'h08, 32'h0, rd, er, lat);
    chk("rd08_lat",  lat,          32'd2);
    chk("rd08_data", rd,           32'hDEADBEEF);
    chk("rd08_err",  {31'h0, er},  32'h0);

    // ---- port 1 illegal accesses ----
    s_rd = rd_cnt; s_wr = wr_cnt;
    do_access(1'b1, 1'b0, 32'h06, 32'h0, rd, er, lat);
    chk("mis_rd_err", {31'h0, er}, 32'h1);
    chk("mis_rd_lat", lat,         32'd2);
    do_access(1'b1, 1'b0, 32'h80, 32'h0, rd, er, lat);
    chk("oor_rd_err", {31'h0, er}, 32'h1);
    do_access(1'b1, 1'b1, 32'h06, 32'hFFFFFFFF, rd, er, lat);
    chk("mis_wr_err", {31'h0, er}, 32'h1);
    do_access(1'b1, 1'b1, 32'h80, 32'hFFFFFFFF, rd, er, lat);
    chk("oor_wr_err", {31'h0, er}, 32'h1);
    do_access(1'b1, 1'b0, 32'h80000008, 32'h0, rd, er, lat);
    chk("hi_rd_err",  {31'h0, er}, 32'h1);
    chk("ill_rdstrb", rd_cnt - s_rd, 32'd0);
    chk("ill_wrstrb", wr_cnt - s_wr, 32'd0);
    chk("ill_mem0",   mem[0],        32'h0);
    chk("ill_mem1",   mem[1],        32'h0);
    chk("ill_mem2",   mem[2],        32'hDEADBEEF);

    // ---- reset during a port 0 write ACCESS ----
    m0_we_i = 1'b1; m0_addr_i = 32'h10; m0_wdata_i = 32'h12345678; m0_req_i = 1'b1;
    tick();
    chk("mr_acc_we", {31'h0, mem_write_o}, 32'h1);
    s_a0 = a0_cnt;
    #2;
    rst_i = 1'b0; m0_req_i = 1'b0;
    #1;
    chk("mr_we",    {31'h0, mem_write_o}, 32'h0);
    chk("mr_addr",  mem_addr_o,           32'h0);
    chk("mr_data",  mem_data_o,           32'h0);
    chk("mr_busy",  {31'h0, busy_o},      32'h0);
    chk("mr_rdata", m0_rdata_o,           32'h0);
    tick();
    rst_i = 1'b1;
    tick();
    chk("mr_mem10", mem[4],        32'h0);
    chk("mr_noack", a0_cnt - s_a0, 32'd0);
    // Both request together: port 0 must win first after reset.
    m0_we_i = 1'b0; m0_addr_i = 32'h10; m0_req_i = 1'b1;
    m1_we_i = 1'b0; m1_addr_i = 32'h08; m1_req_i = 1'b1;
    tick();
    tick();
    chk("mr_gnt_ack0",  {31'h0, m0_ack_o}, 32'h1);
    chk("mr_gnt_ack1",  {31'h0, m1_ack_o}, 32'h0);
    chk("mr_gnt_rd10",  m0_rdata_o,        32'h0);
    tick();
    m0_req_i = 1'b0;
    tick();
    tick();
    chk("mr_m1_ack",   {31'h0, m1_ack_o}, 32'h1);
    chk("mr_m1_rdata", m1_rdata_o,        32'hDEADBEEF);
    tick();
    m1_req_i = 1'b0;

    // ---- port 1 sweep: write all words, then read them back ----
    s_cyc = cyc_cnt; s_busy = busy_cnt; s_rd = rd_cnt; s_wr = wr_cnt;
    for (int i = 0; i < 32; i++) begin
      do_access(1'b1, 1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i * 4), rd, er, lat);
      chk("sw_wr_lat", lat, 32'd2);
    end
    for (int i = 0; i < 32; i++) begin
      do_access(1'b1, 1'b0, 32'(i * 4), 32'h0, rd, er, lat);
      chk("sw_rd_data", rd, 32'hC0DE0000 | 32'(i * 4));
      chk("sw_rd_err",  {31'h0, er}, 32'h0);
    end
    chk("sw_cycles", cyc_cnt - s_cyc,   32'd192);
    chk("sw_busy",   busy_cnt - s_busy, 32'd128);
    chk("sw_rdstrb", rd_cnt - s_rd,     32'd32);
    chk("sw_wrstrb", wr_cnt - s_wr,     32'd32);

    // ---- both ports requesting two reads each, from reset ----
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_order[0] = 2'd0; exp_order[1] = 2'd0; exp_order[2] = 2'd1; exp_order[3] = 2'd1;
`else
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd0; exp_order[3] = 2'd1;
`endif
    for (int i = 0; i < 4; i++) order[i] = 2'd3;
    n0 = 0; n1 = 0; no = 0; drop0 = 1'b0; drop1 = 1'b0;
    s_a0 = dual_cnt;
    m0_we_i = 1'b0; m0_addr_i = 32'h00; m0_req_i = 1'b1;
    m1_we_i = 1'b0; m1_addr_i = 32'h04; m1_req_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (drop0) begin m0_req_i = 1'b0; drop0 = 1'b0; end
      if (drop1) begin m1_req_i = 1'b0; drop1 = 1'b0; end
      if (m0_ack_o) begin
        if (no < 4) order[no] = 2'd0;
        no++; n0++;
        if (n0 == 2) drop0 = 1'b1;
      end
      if (m1_ack_o) begin
        if (no < 4) order[no] = 2'd1;
        no++; n1++;
        if (n1 == 2) drop1 = 1'b1;
      end
      if (n0 == 2 && n1 == 2 && !m0_req_i && !m1_req_i) break;
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    chk("arb_g0",     {30'h0, order[0]}, {30'h0, exp_order[0]});
    chk("arb_g1",     {30'h0, order[1]}, {30'h0, exp_order[1]});
    chk("arb_g2",     {30'h0, order[2]}, {30'h0, exp_order[2]});
    chk("arb_g3",     {30'h0, order[3]}, {30'h0, exp_order[3]});
    chk("arb_nacks",  no,                32'd4);
    chk("arb_dual",   dual_cnt - s_a0,   32'd0);
    chk("arb_rdata0", m0_rdata_o,        32'hC0DE0000);
    chk("arb_rdata1", m1_rdata_o,        32'hC0DE0004);
    chk("all_dual",   dual_cnt,          32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
